// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC sequencer:
//   - Q4.28 angle constants (pi, 2*pi, pi/2) used by range reduction
//   - sequencer state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package cordic_pkg;

   localparam int FRAC_BITS = 28;

   // Q4.28 radians
   localparam logic [31:0] PI      = 32'h3243F6A9;
   localparam logic [31:0] TWO_PI  = 32'h6487ED51;
   localparam logic [31:0] HALF_PI = 32'h1921FB54;

   typedef enum logic [2:0] {
      IDLE,
      WRAP,
      FOLD,
      SETTLE,
      DONE
   } state_t;

endpackage

// File: rtl/cordic_range_reduce.sv
// -----------------------------------------------------------------------------
// cordic_range_reduce
// Combinational range-reduction helper for the CORDIC sequencer. Both stages
// are computed from the same input; the sequencer registers the wrap result
// first and then feeds it back through this block to take the fold result.
//
// Ports:
//   angle       in   N  signed Q4.28 angle
//   wrap_angle  out  N  angle brought into (-pi, pi] by one 2*pi step
//   fold_angle  out  N  angle brought into [-pi/2, pi/2] by one pi step
//   fold_neg    out  1  1 when the fold applied a pi offset
// -----------------------------------------------------------------------------
module cordic_range_reduce
   import cordic_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] angle,
   output logic [N-1:0] wrap_angle,
   output logic [N-1:0] fold_angle,
   output logic         fold_neg
);

   localparam logic signed [N-1:0] PI_S      = N'(PI);
   localparam logic signed [N-1:0] TWO_PI_S  = N'(TWO_PI);
   localparam logic signed [N-1:0] HALF_PI_S = N'(HALF_PI);

   logic signed [N-1:0] a_s;
   assign a_s = $signed(angle);

   // The Q4.28 input range is [-8, 8) and 2*pi > 6.28, so a single step lands
   // inside (-pi, pi] without overflowing N bits.
   always_comb begin
      wrap_angle = angle;
      if (a_s > PI_S)
         wrap_angle = angle - TWO_PI_S;
      else if (a_s <= -PI_S)
         wrap_angle = angle + TWO_PI_S;
   end

   // Exactly +/-pi/2 is left alone; only strictly outside folds by pi.
   always_comb begin
      fold_angle = angle;
      fold_neg   = 1'b0;
      if (a_s > HALF_PI_S) begin
         fold_angle = angle - PI_S;
         fold_neg   = 1'b1;
      end else if (a_s < -HALF_PI_S) begin
         fold_angle = angle + PI_S;
         fold_neg   = 1'b1;
      end
   end

endmodule

// File: rtl/cordic_seq.sv
// -----------------------------------------------------------------------------
// cordic_seq
// Sequencing front/back end around a combinational Q4.28 CORDIC unit.
// One transaction at a time: accept a request, range-reduce the angle to
// [-pi/2, pi/2] (wrap, then fold), drive the CORDIC inputs for SETTLE cycles,
// capture its outputs with quadrant sign correction, and hold the result
// until it is consumed.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready              request handshake (ready only in IDLE)
//   in_trig_rot                    1 = sin/cos, 0 = vector rotation
//   in_angle, in_xi, in_yi         request operands (Q4.28)
//   cu_trig_rot, cu_angle,
//   cu_xi, cu_yi                   stable drive to the CORDIC unit
//   cu_sin, cu_cos, cu_xr, cu_yr   CORDIC unit results
//   out_valid/out_ready            result handshake
//   out_sin, out_cos, out_xr,
//   out_yr                         sign-corrected results
// -----------------------------------------------------------------------------
module cordic_seq #(
   parameter int N      = 32,
   parameter int SETTLE = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_trig_rot,
   input  logic [N-1:0] in_angle,
   input  logic [N-1:0] in_xi,
   input  logic [N-1:0] in_yi,
   output logic         cu_trig_rot,
   output logic [N-1:0] cu_angle,
   output logic [N-1:0] cu_xi,
   output logic [N-1:0] cu_yi,
   input  logic [N-1:0] cu_sin,
   input  logic [N-1:0] cu_cos,
   input  logic [N-1:0] cu_xr,
   input  logic [N-1:0] cu_yr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_sin,
   output logic [N-1:0] out_cos,
   output logic [N-1:0] out_xr,
   output logic [N-1:0] out_yr
);

   import cordic_pkg::*;

   // The SETTLE parameter shadows the enum member of the same name, so the
   // state is always referenced with its package scope.

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   // Negation that saturates the most negative value instead of wrapping.
   function automatic logic [N-1:0] sat_neg(input logic [N-1:0] v);
      if (v == {1'b1, {(N-1){1'b0}}})
         return {1'b0, {(N-1){1'b1}}};
      return -v;
   endfunction

   state_t          state, state_nxt;
   logic            trig_q;
   logic [N-1:0]    angle_q;
   logic [N-1:0]    xi_q;
   logic [N-1:0]    yi_q;
   logic            neg_q;
   logic [CW-1:0]   cnt;
   logic            settle_done;

   logic [N-1:0]    wrap_angle;
   logic [N-1:0]    fold_angle;
   logic            fold_neg;

   cordic_range_reduce #(.N(N)) u_reduce (
      .angle      (angle_q),
      .wrap_angle (wrap_angle),
      .fold_angle (fold_angle),
      .fold_neg   (fold_neg)
   );

   assign in_ready    = (state == cordic_pkg::IDLE);
   assign out_valid   = (state == cordic_pkg::DONE);
   assign settle_done = (cnt == '0);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= cordic_pkg::IDLE;
      else
         state <= state_nxt;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         cordic_pkg::IDLE:   if (in_valid) state_nxt = cordic_pkg::WRAP;
         cordic_pkg::WRAP:   state_nxt = cordic_pkg::FOLD;
         cordic_pkg::FOLD:   state_nxt = cordic_pkg::SETTLE;
         cordic_pkg::SETTLE: if (settle_done) state_nxt = cordic_pkg::DONE;
         cordic_pkg::DONE:   if (out_ready) state_nxt = cordic_pkg::IDLE;
         default:            state_nxt = cordic_pkg::IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_q      <= 1'b0;
         angle_q     <= '0;
         xi_q        <= '0;
         yi_q        <= '0;
         neg_q       <= 1'b0;
         cnt         <= '0;
         cu_trig_rot <= 1'b0;
         cu_angle    <= '0;
         cu_xi       <= '0;
         cu_yi       <= '0;
         out_sin     <= '0;
         out_cos     <= '0;
         out_xr      <= '0;
         out_yr      <= '0;
      end else begin
         case (state)
            cordic_pkg::IDLE: begin
               if (in_valid) begin
                  trig_q  <= in_trig_rot;
                  angle_q <= in_angle;
                  xi_q    <= in_xi;
                  yi_q    <= in_yi;
               end
            end
            cordic_pkg::WRAP: begin
               angle_q <= wrap_angle;
            end
            cordic_pkg::FOLD: begin
               // angle_q already holds the wrapped angle here.
               angle_q     <= fold_angle;
               neg_q       <= fold_neg;
               cu_trig_rot <= trig_q;
               cu_angle    <= fold_angle;
               cu_xi       <= trig_q ? '0 : xi_q;
               cu_yi       <= trig_q ? '0 : yi_q;
               cnt         <= CW'(SETTLE - 1);
            end
            cordic_pkg::SETTLE: begin
               if (settle_done) begin
                  // A pi offset flips sin and cos alike, and both components
                  // of a rotated vector, so one rule serves both modes.
                  out_sin <= neg_q ? sat_neg(cu_sin) : cu_sin;
                  out_cos <= neg_q ? sat_neg(cu_cos) : cu_cos;
                  out_xr  <= neg_q ? sat_neg(cu_xr)  : cu_xr;
                  out_yr  <= neg_q ? sat_neg(cu_yr)  : cu_yr;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_seq.sv
// Self-checking bench for cordic_seq: a stand-in CORDIC unit returns values
// chosen per transaction; a reference model reduces the angle by repeated
// 2*pi/pi steps on plain integers and predicts the corrected outputs.
module tb_cordic_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid, in_ready, in_trig_rot;
   logic [31:0] in_angle, in_xi, in_yi;
   logic        cu_trig_rot;
   logic [31:0] cu_angle, cu_xi, cu_yi;
   logic [31:0] cu_sin, cu_cos, cu_xr, cu_yr;
   logic        out_valid, out_ready;
   logic [31:0] out_sin, out_cos, out_xr, out_yr;

   cordic_seq #(.N(32), .SETTLE(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_trig_rot(in_trig_rot),
      .in_angle(in_angle), .in_xi(in_xi), .in_yi(in_yi),
      .cu_trig_rot(cu_trig_rot), .cu_angle(cu_angle), .cu_xi(cu_xi), .cu_yi(cu_yi),
      .cu_sin(cu_sin), .cu_cos(cu_cos), .cu_xr(cu_xr), .cu_yr(cu_yr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sin(out_sin), .out_cos(out_cos), .out_xr(out_xr), .out_yr(out_yr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        trig;
      logic [31:0] angle, xi, yi;
      logic [31:0] s, c, xr, yr;
      int          acc;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0;
   int   hold = 0;
   bit   rnd_ready = 1'b1;
   bit   prev_valid = 1'b0, hs_prev = 1'b0, has_cur = 1'b0;
   int   vcnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference range reduction: whole 2*pi turns until in (-pi, pi], then a
   // half turn if outside [-pi/2, pi/2].
   function automatic void ref_reduce(input logic [31:0] a, output logic [31:0] r, output bit neg);
      longint v, pi, tp, hp;
      pi = longint'(32'h3243F6A9);
      tp = longint'(32'h6487ED51);
      hp = longint'(32'h1921FB54);
      v  = longint'($signed(a));
      while (v > pi)   v -= tp;
      while (v <= -pi) v += tp;
      neg = 1'b0;
      if (v > hp) begin
         v -= pi; neg = 1'b1;
      end else if (v < -hp) begin
         v += pi; neg = 1'b1;
      end
      r = v[31:0];
   endfunction

   function automatic logic [31:0] ref_neg(input logic [31:0] x);
      longint v;
      v = -longint'($signed(x));
      if (v > 64'sd2147483647) v = 64'sd2147483647;
      return v[31:0];
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         hs_prev    = 1'b0;
         has_cur    = 1'b0;
         out_ready  = 1'b0;
      end else begin
         if (hs_prev) begin
            chk("valid_clear_after_hs", {31'b0, out_valid}, 32'h0);
            chk("in_ready_after_hs",    {31'b0, in_ready},  32'h1);
            hs_prev = 1'b0;
         end else if (out_valid) begin
            if (!prev_valid) begin
               if (q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_out: out_valid with nothing outstanding (cycle %0d)", cyc);
                  has_cur = 1'b0;
               end else begin
                  cur = q.pop_front();
                  has_cur = 1'b1;
                  chk("latency",     32'(cyc - cur.acc), 32'd4);
                  chk("cu_trig_rot", {31'b0, cu_trig_rot}, {31'b0, cur.trig});
                  chk("cu_angle",    cu_angle, cur.angle);
                  chk("cu_xi",       cu_xi,    cur.xi);
                  chk("cu_yi",       cu_yi,    cur.yi);
                  chk("out_sin",     out_sin,  cur.s);
                  chk("out_cos",     out_cos,  cur.c);
                  chk("out_xr",      out_xr,   cur.xr);
                  chk("out_yr",      out_yr,   cur.yr);
               end
               vcnt = 0;
            end else if (has_cur) begin
               chk("hold_sin", out_sin, cur.s);
               chk("hold_cos", out_cos, cur.c);
               chk("hold_xr",  out_xr,  cur.xr);
               chk("hold_yr",  out_yr,  cur.yr);
            end
            chk("in_ready_busy", {31'b0, in_ready}, 32'h0);
            out_ready = (vcnt < hold) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            vcnt++;
            if (out_ready) hs_prev = 1'b1;
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
         prev_valid = out_valid;
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic trig, input logic [31:0] ang, input logic [31:0] xi,
                        input logic [31:0] yi, input logic [31:0] ss, input logic [31:0] sc,
                        input logic [31:0] sxr, input logic [31:0] syr);
      exp_t e;
      logic [31:0] r;
      bit neg;
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready stuck at 0");
            return;
         end
      end
      cu_sin = ss; cu_cos = sc; cu_xr = sxr; cu_yr = syr;
      in_trig_rot = trig; in_angle = ang; in_xi = xi; in_yi = yi;
      in_valid = 1'b1;
      ref_reduce(ang, r, neg);
      e.trig  = trig;
      e.angle = r;
      e.xi    = trig ? 32'h0 : xi;
      e.yi    = trig ? 32'h0 : yi;
      e.s     = neg ? ref_neg(ss)  : ss;
      e.c     = neg ? ref_neg(sc)  : sc;
      e.xr    = neg ? ref_neg(sxr) : sxr;
      e.yr    = neg ? ref_neg(syr) : syr;
      e.acc   = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      // Scramble inputs so a design that reads them late is caught.
      in_trig_rot = 1'($urandom_range(0, 1));
      in_angle = $urandom; in_xi = $urandom; in_yi = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: result never consumed");
      end
      @(negedge clk);
   endtask

   logic [31:0] bnd [0:6];

   initial begin
      in_valid = 1'b0; in_trig_rot = 1'b0;
      in_angle = '0; in_xi = '0; in_yi = '0;
      cu_sin = '0; cu_cos = '0; cu_xr = '0; cu_yr = '0;
      out_ready = 1'b0;
      bnd[0] = 32'h3243F6A9; bnd[1] = 32'hCDBC0957; bnd[2] = 32'h1921FB54;
      bnd[3] = 32'hE6DE04AC; bnd[4] = 32'h7FFFFFFF; bnd[5] = 32'h80000000;
      bnd[6] = 32'h3243F6AA;

      #1 rst = 1'b1;
      #2;
      chk("rst_in_ready",  {31'b0, in_ready},    32'h1);
      chk("rst_out_valid", {31'b0, out_valid},   32'h0);
      chk("rst_cu_trig",   {31'b0, cu_trig_rot}, 32'h0);
      chk("rst_cu_angle",  cu_angle, 32'h0);
      chk("rst_out_sin",   out_sin,  32'h0);
      chk("rst_out_yr",    out_yr,   32'h0);
      @(negedge clk);
      #2 rst = 1'b0;

      // pi/3, trig mode
      issue(1'b1, 32'h10C15238, 32'h0, 32'h0, 32'h0DDB3D74, 32'h08000000, 32'h01234567, 32'h089ABCDE);
      drain();
      // 7.0 wraps, no fold
      issue(1'b1, 32'h70000000, 32'h11111111, 32'h22222222, 32'h0A000000, 32'h0B000000, 32'h0, 32'h0);
      drain();
      // -2.0 folds, rotation mode
      issue(1'b0, 32'hE0000000, 32'h0B504F33, 32'h0B504F33, 32'h00100000, 32'h00200000, 32'h05A82799, 32'hF2345678);
      drain();
      // exactly pi: no wrap, folds to 0, saturating negate of cos
      issue(1'b1, 32'h3243F6A9, 32'h0, 32'h0, 32'h00000001, 32'h80000000, 32'h0, 32'h0);
      drain();
      // exactly -pi and exactly pi/2
      issue(1'b0, 32'hCDBC0957, 32'h01000000, 32'hFF000000, 32'h0, 32'h0, 32'h80000000, 32'h01000000);
      drain();
      issue(1'b1, 32'h1921FB54, 32'h0, 32'h0, 32'h10000000, 32'h00000123, 32'h0, 32'h0);
      drain();

      // Consumer stalls 5 cycles; stray requests while busy must be ignored.
      hold = 5; rnd_ready = 1'b0;
      issue(1'b0, 32'h40000000, 32'h03000000, 32'h04000000, 32'h1, 32'h2, 32'h0C000000, 32'h0D000000);
      for (int i = 0; i < 8; i++) begin
         in_valid = ~in_valid;
         in_angle = $urandom;
         @(negedge clk);
      end
      in_valid = 1'b0;
      drain();
      hold = 0; rnd_ready = 1'b1;

      // Reset during SETTLE discards the request.
      issue(1'b1, 32'h20000000, 32'h0, 32'h0, 32'h05555555, 32'h06666666, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_in_ready",  {31'b0, in_ready},  32'h1);
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("mid_rst_cu_angle",  cu_angle, 32'h0);
      chk("mid_rst_out_sin",   out_sin,  32'h0);
      chk("mid_rst_out_cos",   out_cos,  32'h0);
      q.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("no_valid_after_rst", {31'b0, out_valid}, 32'h0);
      end
      issue(1'b0, 32'hA0000000, 32'h00800000, 32'h00400000, 32'h0, 32'h0, 32'h00ABCDEF, 32'hFFF00000);
      drain();

      // Randomized traffic with random consumer back-pressure.
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a, s, c, x, y;
         a = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 6)] : $urandom;
         s = $urandom; c = $urandom; x = $urandom; y = $urandom;
         if ($urandom_range(0, 7) == 0) c = 32'h80000000;
         if ($urandom_range(0, 7) == 0) y = 32'h80000000;
         issue(1'($urandom_range(0, 1)), a, $urandom, $urandom, s, c, x, y);
         if ($urandom_range(0, 1) == 0) drain();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
